// File: rtl/vga_frame_sched.sv
// rtl/vga_frame_sched.sv - raster timing, page-flip scheduling, vblank irq and underflow counting
module vga_frame_sched #(
    parameter int                    H_VISIBLE      = 1024,
    parameter int                    H_FRONT        = 24,
    parameter int                    H_SYNC         = 136,
    parameter int                    H_BACK         = 160,
    parameter int                    V_VISIBLE      = 768,
    parameter int                    V_FRONT        = 3,
    parameter int                    V_SYNC         = 6,
    parameter int                    V_BACK         = 29,
    parameter int                    PREFETCH_LINES = 1,
    parameter int                    ADDR_WIDTH     = 20,
    parameter logic [ADDR_WIDTH-1:0] RESET_BASE     = '0
) (
    input  logic                  clk_vga,
    input  logic                  rst,
    input  logic                  flip_req,
    input  logic [ADDR_WIDTH-1:0] flip_base,
    output logic                  flip_ack,
    output logic [ADDR_WIDTH-1:0] frame_base,
    output logic                  fetch_en,
    output logic                  in_display,
    output logic                  vblank,
    output logic                  vblank_irq,
    input  logic                  irq_ack,
    output logic [15:0]           frame_count,
    input  logic                  lb_rd,
    input  logic                  lb_empty,
    output logic [7:0]            underflow_cnt,
    input  logic                  underflow_clr
);

    localparam int H_WHOLE = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_WHOLE = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
    localparam int VS0     = V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_WHOLE);
    localparam int VW      = $clog2(V_WHOLE);
    localparam int HW1     = HW + 1;
    localparam int VW1     = VW + 1;

    // Bounds are one bit wider than the counters so an end-exclusive bound equal to the total still fits.
    localparam logic [HW:0] H_LAST = HW1'(H_WHOLE - 1);
    localparam logic [HW:0] H_ACT0 = HW1'(H_SYNC + H_BACK);
    localparam logic [HW:0] H_ACT1 = HW1'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [VW:0] V_LAST = VW1'(V_WHOLE - 1);
    localparam logic [VW:0] V_ACT0 = VW1'(VS0);
    localparam logic [VW:0] V_ACT1 = VW1'(VS0 + V_VISIBLE);
    localparam logic [VW:0] V_VBE  = VW1'(VS0 + V_VISIBLE - 1);
    localparam logic [VW:0] V_FE0  = VW1'(VS0 - PREFETCH_LINES);

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_PEND  = 2'd1,
        F_ACKED = 2'd2
    } flip_state_t;

    logic [HW-1:0]         r_h;
    logic [VW-1:0]         r_v;
    logic                  r_in_display;
    logic                  r_vblank;
    logic                  r_fetch_en;
    flip_state_t           r_fstate;
    flip_state_t           w_fstate_nxt;
    logic [ADDR_WIDTH-1:0] r_pend_base;
    logic [ADDR_WIDTH-1:0] r_frame_base;
    logic                  r_flip_ack;
    logic                  r_vblank_irq;
    logic [15:0]           r_frame_count;
    logic [7:0]            r_underflow_cnt;

    logic                  w_h_last;
    logic                  w_v_last;
    logic                  w_vbe;
    logic                  w_h_act;
    logic                  w_v_act;
    logic                  w_v_fetch;
    logic                  w_capture;
    logic                  w_apply;
    logic                  w_uf_event;
    logic                  w_uf_sat;

    assign w_h_last  = ({1'b0, r_h} == H_LAST);
    assign w_v_last  = ({1'b0, r_v} == V_LAST);
    assign w_vbe     = w_h_last && ({1'b0, r_v} == V_VBE);
    assign w_h_act   = ({1'b0, r_h} >= H_ACT0) && ({1'b0, r_h} < H_ACT1);
    assign w_v_act   = ({1'b0, r_v} >= V_ACT0) && ({1'b0, r_v} < V_ACT1);
    assign w_v_fetch = ({1'b0, r_v} >= V_FE0) && ({1'b0, r_v} < V_ACT1);

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Flags lag the counters by one cycle so they come straight from flops.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_in_display <= 1'b0;
            r_vblank     <= 1'b1;
            r_fetch_en   <= 1'b0;
        end else begin
            r_in_display <= w_h_act && w_v_act;
            r_vblank     <= !w_v_act;
            r_fetch_en   <= w_v_fetch;
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_fstate <= F_IDLE;
        end else begin
            r_fstate <= w_fstate_nxt;
        end
    end

    // A request first seen on the vblank-entry cycle is only latched; it lands one frame later.
    always_comb begin
        w_fstate_nxt = r_fstate;
        w_capture    = 1'b0;
        w_apply      = 1'b0;
        case (r_fstate)
            F_IDLE: begin
                if (flip_req) begin
                    w_capture    = 1'b1;
                    w_fstate_nxt = F_PEND;
                end
            end
            F_PEND: begin
                if (w_vbe) begin
                    w_apply      = 1'b1;
                    w_fstate_nxt = F_ACKED;
                end
            end
            F_ACKED: begin
                if (!flip_req) begin
                    w_fstate_nxt = F_IDLE;
                end
            end
            default: begin
                w_fstate_nxt = F_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_pend_base  <= RESET_BASE;
            r_frame_base <= RESET_BASE;
            r_flip_ack   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_pend_base <= flip_base;
            end
            if (w_apply) begin
                r_frame_base <= r_pend_base;
            end
            r_flip_ack <= w_apply;
        end
    end

    // Set has priority over acknowledge so a vblank entry is never lost.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_vblank_irq  <= 1'b0;
            r_frame_count <= '0;
        end else if (w_vbe) begin
            r_vblank_irq  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
        end else if (irq_ack) begin
            r_vblank_irq  <= 1'b0;
        end
    end

    assign w_uf_event = lb_rd && lb_empty && r_in_display;
    assign w_uf_sat   = &r_underflow_cnt;

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_underflow_cnt <= '0;
        end else if (underflow_clr) begin
            r_underflow_cnt <= w_uf_event ? 8'd1 : 8'd0;
        end else if (w_uf_event && !w_uf_sat) begin
            r_underflow_cnt <= r_underflow_cnt + 8'd1;
        end
    end

    assign flip_ack      = r_flip_ack;
    assign frame_base    = r_frame_base;
    assign fetch_en      = r_fetch_en;
    assign in_display    = r_in_display;
    assign vblank        = r_vblank;
    assign vblank_irq    = r_vblank_irq;
    assign frame_count   = r_frame_count;
    assign underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_vga_frame_sched.sv
// tb/tb_vga_frame_sched.sv - scoreboard bench for vga_frame_sched on a reduced raster
module tb_vga_frame_sched;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 6, VF = 1, VSY = 2, VB = 3, PF = 1;
    localparam int HWH   = HV + HF + HS + HB;
    localparam int VWH   = VV + VF + VSY + VB;
    localparam int VS0   = VSY + VB;
    localparam int HA0   = HS + HB;
    localparam int FRAME = HWH * VWH;
    localparam logic [19:0] RB = 20'h00100;

    logic        clk_vga = 1'b0;
    logic        rst, flip_req, irq_ack, lb_rd, lb_empty, underflow_clr;
    logic [19:0] flip_base, frame_base;
    logic        flip_ack, fetch_en, in_display, vblank, vblank_irq;
    logic [15:0] frame_count;
    logic [7:0]  underflow_cnt;

    vga_frame_sched #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .PREFETCH_LINES(PF), .ADDR_WIDTH(20), .RESET_BASE(RB)
    ) dut (
        .clk_vga(clk_vga), .rst(rst), .flip_req(flip_req), .flip_base(flip_base),
        .flip_ack(flip_ack), .frame_base(frame_base), .fetch_en(fetch_en),
        .in_display(in_display), .vblank(vblank), .vblank_irq(vblank_irq),
        .irq_ack(irq_ack), .frame_count(frame_count), .lb_rd(lb_rd),
        .lb_empty(lb_empty), .underflow_cnt(underflow_cnt), .underflow_clr(underflow_clr)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct packed {
        logic        in_display;
        logic        vblank;
        logic        fetch_en;
        logic        flip_ack;
        logic        irq;
        logic [19:0] fb;
        logic [15:0] fc;
        logic [7:0]  uf;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    int          m_h, m_v, m_st, m_fc, m_uf;
    logic        m_ind, m_vb, m_fe, m_ack, m_irq;
    logic [19:0] m_fb, m_pend;

    function automatic bit at_vbe();
        return (m_h == HWH - 1) && (m_v == VS0 + VV - 1);
    endfunction

    // Reference model: predicts the registered outputs after the coming edge, then clocks.
    task automatic cycle();
        exp_t e;
        bit   vbe;
        bit   ev;
        bit   vis;
        if (rst) begin
            m_h = 0; m_v = 0; m_st = 0; m_fc = 0; m_uf = 0;
            m_ind = 0; m_vb = 1; m_fe = 0; m_ack = 0; m_irq = 0;
            m_fb = RB;
        end else begin
            vbe = at_vbe();
            ev  = lb_rd && lb_empty && m_ind;
            if (underflow_clr) m_uf = ev ? 1 : 0;
            else if (ev && m_uf < 255) m_uf = m_uf + 1;
            vis   = (m_v >= VS0) && (m_v < VS0 + VV);
            m_ind = vis && (m_h >= HA0) && (m_h < HA0 + HV);
            m_vb  = !vis;
            m_fe  = (m_v >= VS0 - PF) && (m_v < VS0 + VV);
            m_ack = 0;
            case (m_st)
                0: if (flip_req) begin m_pend = flip_base; m_st = 1; end
                1: if (vbe) begin m_fb = m_pend; m_ack = 1; m_st = 2; end
                default: if (!flip_req) m_st = 0;
            endcase
            if (vbe) begin m_irq = 1; m_fc = (m_fc + 1) % 65536; end
            else if (irq_ack) m_irq = 0;
            if (m_h == HWH - 1) begin
                m_h = 0;
                m_v = (m_v == VWH - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        e.in_display = m_ind; e.vblank = m_vb; e.fetch_en = m_fe;
        e.flip_ack = m_ack; e.irq = m_irq; e.fb = m_fb;
        e.fc = 16'(m_fc); e.uf = 8'(m_uf);
        sb.push_back(e);
        @(posedge clk_vga);
        #1;
    endtask

    task automatic advance(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            cycle();
            e = sb.pop_front();
        end
    endtask

    task automatic advance_to_vbe();
        exp_t e;
        int   g = 0;
        while (!at_vbe() && g < 2 * FRAME) begin
            cycle();
            e = sb.pop_front();
            g++;
        end
        n_checks++;
        if (!at_vbe()) begin n_fail++; $display("FAIL vbe_timeout: no vblank entry within %0d cycles", g); end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1; flip_req = 0; flip_base = '0; irq_ack = 0;
        lb_rd = 0; lb_empty = 0; underflow_clr = 0;
        repeat (3) begin cycle(); e = sb.pop_front(); end
        n_checks++; if (in_display !== 1'b0) begin n_fail++; $display("FAIL reset.in_display got %b want 0", in_display); end
        n_checks++; if (vblank !== 1'b1) begin n_fail++; $display("FAIL reset.vblank got %b want 1", vblank); end
        n_checks++; if (fetch_en !== 1'b0) begin n_fail++; $display("FAIL reset.fetch_en got %b want 0", fetch_en); end
        n_checks++; if (flip_ack !== 1'b0) begin n_fail++; $display("FAIL reset.flip_ack got %b want 0", flip_ack); end
        n_checks++; if (vblank_irq !== 1'b0) begin n_fail++; $display("FAIL reset.vblank_irq got %b want 0", vblank_irq); end
        n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset.frame_count got %0d want 0", frame_count); end
        n_checks++; if (underflow_cnt !== 8'd0) begin n_fail++; $display("FAIL reset.underflow_cnt got %0d want 0", underflow_cnt); end
        n_checks++; if (frame_base !== RB) begin n_fail++; $display("FAIL reset.frame_base got %h want %h", frame_base, RB); end
        rst = 0;
    endtask

    task automatic test_raster();
        exp_t e;
        int   run = 0, runs = 0, disp = 0, rises = 0, fe_at = -1;
        logic irq_prev = 1'b0;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            cycle();
            e = sb.pop_front();
            n_checks++; if (in_display !== e.in_display) begin n_fail++; $display("FAIL raster.in_display cyc %0d got %b want %b", i, in_display, e.in_display); end
            n_checks++; if (vblank !== e.vblank) begin n_fail++; $display("FAIL raster.vblank cyc %0d got %b want %b", i, vblank, e.vblank); end
            n_checks++; if (fetch_en !== e.fetch_en) begin n_fail++; $display("FAIL raster.fetch_en cyc %0d got %b want %b", i, fetch_en, e.fetch_en); end
            n_checks++; if (vblank_irq !== e.irq) begin n_fail++; $display("FAIL raster.vblank_irq cyc %0d got %b want %b", i, vblank_irq, e.irq); end
            if (in_display === 1'b1) begin
                run++; disp++;
            end else if (run != 0) begin
                n_checks++; if (run != HV) begin n_fail++; $display("FAIL raster.line_len got %0d want %0d", run, HV); end
                runs++; run = 0;
            end
            if (vblank_irq === 1'b1 && irq_prev !== 1'b1) rises++;
            irq_prev = vblank_irq;
            if (fetch_en === 1'b1 && fe_at < 0) fe_at = i;
            irq_ack = vblank_irq;
        end
        irq_ack = 0;
        n_checks++; if (disp != 2 * VV * HV) begin n_fail++; $display("FAIL raster.disp_cycles got %0d want %0d", disp, 2 * VV * HV); end
        n_checks++; if (runs != 2 * VV) begin n_fail++; $display("FAIL raster.lines got %0d want %0d", runs, 2 * VV); end
        n_checks++; if (rises != 2) begin n_fail++; $display("FAIL raster.irq_rises got %0d want 2", rises); end
        n_checks++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL raster.frame_count got %0d want 2", frame_count); end
        n_checks++; if (fe_at != (VS0 - PF) * HWH + 1) begin n_fail++; $display("FAIL raster.fetch_rise got %0d want %0d", fe_at, (VS0 - PF) * HWH + 1); end
    endtask

    task automatic test_flip();
        exp_t e;
        int   acks = 0;
        advance(20);
        flip_base = 20'h40000;
        flip_req  = 1;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            cycle();
            e = sb.pop_front();
            n_checks++; if (flip_ack !== e.flip_ack) begin n_fail++; $display("FAIL flip.ack cyc %0d got %b want %b", i, flip_ack, e.flip_ack); end
            n_checks++; if (frame_base !== e.fb) begin n_fail++; $display("FAIL flip.base cyc %0d got %h want %h", i, frame_base, e.fb); end
            if (flip_ack === 1'b1) begin
                acks++;
                n_checks++; if (frame_base !== 20'h40000) begin n_fail++; $display("FAIL flip.applied got %h want 40000", frame_base); end
                flip_base = 20'h55555;
            end else if (acks == 0) begin
                n_checks++; if (frame_base !== RB) begin n_fail++; $display("FAIL flip.early got %h want %h", frame_base, RB); end
            end
        end
        n_checks++; if (acks != 1) begin n_fail++; $display("FAIL flip.ack_count got %0d want 1", acks); end
        n_checks++; if (frame_base !== 20'h40000) begin n_fail++; $display("FAIL flip.held got %h want 40000", frame_base); end
        flip_req = 0;
        advance(2);
    endtask

    task automatic test_flip_on_vbe();
        exp_t e;
        int   found = -1;
        advance_to_vbe();
        flip_req  = 1;
        flip_base = 20'h0ABCD;
        for (int i = 1; i <= FRAME + 10; i++) begin
            cycle();
            e = sb.pop_front();
            n_checks++; if (flip_ack !== e.flip_ack) begin n_fail++; $display("FAIL vbeflip.ack cyc %0d got %b want %b", i, flip_ack, e.flip_ack); end
            n_checks++; if (frame_base !== e.fb) begin n_fail++; $display("FAIL vbeflip.base cyc %0d got %h want %h", i, frame_base, e.fb); end
            if (i == 1) begin
                n_checks++; if (flip_ack !== 1'b0 || frame_base !== 20'h40000) begin n_fail++; $display("FAIL vbeflip.same_frame ack %b base %h want 0 40000", flip_ack, frame_base); end
            end
            if (i == 2) flip_base = 20'h11111;
            if (flip_ack === 1'b1 && found < 0) found = i;
        end
        n_checks++; if (found != FRAME + 1) begin n_fail++; $display("FAIL vbeflip.ack_cycle got %0d want %0d", found, FRAME + 1); end
        n_checks++; if (frame_base !== 20'h0ABCD) begin n_fail++; $display("FAIL vbeflip.base_final got %h want 0abcd", frame_base); end
        flip_req = 0;
        advance(2);
    endtask

    task automatic test_irq_ack();
        exp_t e;
        advance_to_vbe();
        irq_ack = 1;
        cycle();
        e = sb.pop_front();
        n_checks++; if (vblank_irq !== 1'b1) begin n_fail++; $display("FAIL irq.set_wins got %b want 1", vblank_irq); end
        n_checks++; if (frame_count !== e.fc) begin n_fail++; $display("FAIL irq.frame_count got %0d want %0d", frame_count, e.fc); end
        cycle();
        e = sb.pop_front();
        n_checks++; if (vblank_irq !== 1'b0) begin n_fail++; $display("FAIL irq.cleared got %b want 0", vblank_irq); end
        n_checks++; if (vblank_irq !== e.irq) begin n_fail++; $display("FAIL irq.model got %b want %b", vblank_irq, e.irq); end
        irq_ack = 0;
    endtask

    task automatic test_underflow();
        exp_t e;
        int   events = 0, g = 0;
        lb_empty = 1;
        while (events < 300 && g < 8 * FRAME) begin
            lb_rd = in_display;
            if (in_display === 1'b1) events++;
            cycle();
            e = sb.pop_front();
            n_checks++; if (underflow_cnt !== e.uf) begin n_fail++; $display("FAIL uf.count cyc %0d got %0d want %0d", g, underflow_cnt, e.uf); end
            g++;
        end
        lb_rd = 0;
        n_checks++; if (events != 300) begin n_fail++; $display("FAIL uf.events got %0d want 300", events); end
        n_checks++; if (underflow_cnt !== 8'd255) begin n_fail++; $display("FAIL uf.saturate got %0d want 255", underflow_cnt); end
        g = 0;
        while (in_display !== 1'b1 && g < FRAME) begin
            cycle(); e = sb.pop_front(); g++;
        end
        lb_rd = 1; underflow_clr = 1;
        cycle();
        e = sb.pop_front();
        n_checks++; if (underflow_cnt !== 8'd1) begin n_fail++; $display("FAIL uf.clr_event got %0d want 1", underflow_cnt); end
        n_checks++; if (underflow_cnt !== e.uf) begin n_fail++; $display("FAIL uf.clr_model got %0d want %0d", underflow_cnt, e.uf); end
        underflow_clr = 0;
        for (int i = 0; i < 3 * HWH; i++) begin
            lb_rd = !in_display;
            cycle();
            e = sb.pop_front();
            n_checks++; if (underflow_cnt !== 8'd1) begin n_fail++; $display("FAIL uf.outside cyc %0d got %0d want 1", i, underflow_cnt); end
        end
        lb_rd = 0; lb_empty = 0;
    endtask

    task automatic test_reset_pend();
        exp_t e;
        int   g = 0, acks = 0, fe_at = -1;
        while (!(m_v == 1 && m_h == 0) && g < 2 * FRAME) begin
            cycle(); e = sb.pop_front(); g++;
        end
        flip_base = 20'h12345;
        flip_req  = 1;
        advance(3);
        rst = 1; flip_req = 0;
        advance(2);
        rst = 0;
        n_checks++; if (frame_base !== RB) begin n_fail++; $display("FAIL rstpend.base got %h want %h", frame_base, RB); end
        n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL rstpend.frame_count got %0d want 0", frame_count); end
        n_checks++; if (underflow_cnt !== 8'd0) begin n_fail++; $display("FAIL rstpend.uf got %0d want 0", underflow_cnt); end
        for (int i = 1; i <= FRAME + 20; i++) begin
            cycle();
            e = sb.pop_front();
            n_checks++; if (frame_base !== RB) begin n_fail++; $display("FAIL rstpend.base_run cyc %0d got %h want %h", i, frame_base, RB); end
            n_checks++; if (in_display !== e.in_display) begin n_fail++; $display("FAIL rstpend.in_display cyc %0d got %b want %b", i, in_display, e.in_display); end
            if (flip_ack === 1'b1) acks++;
            if (fetch_en === 1'b1 && fe_at < 0) fe_at = i;
        end
        n_checks++; if (acks != 0) begin n_fail++; $display("FAIL rstpend.acks got %0d want 0", acks); end
        n_checks++; if (fe_at != (VS0 - PF) * HWH + 1) begin n_fail++; $display("FAIL rstpend.fetch_rise got %0d want %0d", fe_at, (VS0 - PF) * HWH + 1); end
        n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL rstpend.frame_count_run got %0d want 1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_flip();
        test_flip_on_vbe();
        test_irq_ack();
        test_underflow();
        test_reset_pend();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_frame_sched.md
Name: vga_frame_sched

Overview:
- Frame-level scheduler for the VGA scan-out path, in the clk_vga domain.
- Owns the raster position and decides when the fetch engine may prefetch lines.
- Applies double-buffer page flips only at vblank entry and raises a vblank interrupt.
- Counts line-buffer underflows so software can detect a starved display datapath.

Parameters:
- H_VISIBLE, 1024, visible pixels per line
- H_FRONT, 24, horizontal front porch
- H_SYNC, 136, horizontal sync width
- H_BACK, 160, horizontal back porch
- V_VISIBLE, 768, visible lines
- V_FRONT, 3, vertical front porch
- V_SYNC, 6, vertical sync lines
- V_BACK, 29, vertical back porch
- PREFETCH_LINES, 1, lines before the first visible line at which fetch_en rises (1..V_BACK)
- ADDR_WIDTH, 20, width of frame base address
- RESET_BASE, 0, frame_base after reset

Ports:
- clk_vga  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- flip_req  in  1  level request for a page flip; held until flip_ack
- flip_base  in  ADDR_WIDTH  new frame base; valid while flip_req is high
- flip_ack  out  1  one-cycle pulse when the flip takes effect
- frame_base  out  ADDR_WIDTH  base address the fetcher uses for the current frame
- fetch_en  out  1  fetch window enable for the memory-side fetcher
- in_display  out  1  raster is inside the visible area
- vblank  out  1  raster is outside the visible lines
- vblank_irq  out  1  sticky interrupt, set at vblank entry
- irq_ack  in  1  clears vblank_irq
- frame_count  out  16  completed-frame counter
- lb_rd  in  1  display pipe pops the line buffer
- lb_empty  in  1  line buffer empty flag (clk_vga domain)
- underflow_cnt  out  8  saturating underflow event counter
- underflow_clr  in  1  clears underflow_cnt

Behaviour:
- Raster counters
  - h,v counters follow the order sync, back, visible, front.
  - H_WHOLE = sum of the four H_* parameters; V_WHOLE likewise.
  - h wraps from H_WHOLE-1 to 0; v increments on the h wrap and wraps from V_WHOLE-1 to 0.
  - Reset sets both counters to 0.
- Display and blanking flags (registered, one cycle after the counter value)
  - in_display = h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE) and v in [VS0, VS0+V_VISIBLE), where VS0 = V_SYNC+V_BACK.
  - vblank = v outside [VS0, VS0+V_VISIBLE).
  - fetch_en = v in [VS0-PREFETCH_LINES, VS0+V_VISIBLE).
- Event VBE (vblank entry): h==H_WHOLE-1 and v==VS0+V_VISIBLE-1. All frame-rate actions happen on the VBE cycle and are visible the next cycle.
- Flip FSM, states F_IDLE, F_PEND, F_ACKED:
  - F_IDLE: if flip_req, capture flip_base into pend_base and go to F_PEND.
  - F_PEND: on VBE, set frame_base <= pend_base, pulse flip_ack for 1 cycle, and go to F_ACKED.
  - F_ACKED: stay until flip_req is low, then go to F_IDLE.
  - A request first seen on the VBE cycle while in F_IDLE is only captured. It is applied at the next VBE, one full frame later.
  - flip_base changes while in F_PEND are ignored.
  - frame_base never changes except at VBE or reset.
- IRQ and frame count
  - On VBE, vblank_irq <= 1 and frame_count <= frame_count+1, wrapping at 16 bits (0xFFFF -> 0).
  - irq_ack clears vblank_irq. If irq_ack and VBE occur in the same cycle, set wins.
- Underflow
  - An event is lb_rd && lb_empty while in_display.
  - Each event increments underflow_cnt, saturating at 255.
  - underflow_clr zeroes the counter. Clear together with an event gives 1.
- Reset values
  - Counters 0; flip FSM in F_IDLE; frame_base=RESET_BASE.
  - flip_ack=0, vblank_irq=0, frame_count=0, underflow_cnt=0.
  - in_display=0, vblank=1, fetch_en=0.
  - Reset mid-F_PEND discards pend_base and issues no ack.

Test Plan:
1. Reset, free-run 2 frames (2×806×1344 cycles) -> vblank_irq rises once per frame; frame_count=2; in_display high exactly 1024 cycles per visible line, 768 lines per frame.
2. flip_req=1, flip_base=0x40000 asserted mid-frame -> frame_base stays 0 until VBE; then frame_base=0x40000 and flip_ack is a single 1-cycle pulse; FSM stays in F_ACKED until flip_req drops.
3. flip_req first asserted exactly on the VBE cycle -> no change this frame; frame_base updates and flip_ack pulses at the following VBE.
4. irq_ack held on the VBE cycle with vblank_irq=1 -> vblank_irq remains 1; irq_ack on the next cycle -> 0.
5. lb_empty=1 with lb_rd pulsing 300 times inside display -> underflow_cnt=255; underflow_clr together with one event -> 1; lb_rd&&lb_empty outside display -> no count.
6. rst asserted while in F_PEND with flip_base=0x12345 -> frame_base=RESET_BASE, no flip_ack after reset, counters restart at 0; fetch_en rises at line VS0-PREFETCH_LINES (34 for defaults).
